dmem_loader: RTL and testbench



---
 rtl/dmem_loader_if.sv | 33 +++
 rtl/dmem_loader.sv | 120 ++++++++++++
 tb/tb_dmem_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_loader_if.sv
// Bundles the CPU data port, the preload byte stream and the load status
// of dmem_loader. The master side is the CPU / stream source, the slave
// side is the memory itself.
interface dmem_loader_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int ADDR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hold;
    logic              load_start;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;
    logic [DATA_W-1:0] ld_csum;

    modport master (
        output cpu_addr, cpu_we, cpu_wdata, load_start, ld_data, ld_valid, ld_last,
        input  cpu_rdata, cpu_hold, ld_ready, ld_done, ld_count, ld_csum
    );

    modport slave (
        input  cpu_addr, cpu_we, cpu_wdata, load_start, ld_data, ld_valid, ld_last,
        output cpu_rdata, cpu_hold, ld_ready, ld_done, ld_count, ld_csum
    );
endinterface

// File: rtl/dmem_loader.sv
// Register-file data memory for the single-cycle CPU with a streaming
// preload engine. While a load runs the CPU is stalled and its writes are
// dropped; reads keep returning the live array contents.
//
// state | meaning
// IDLE  | CPU owns the array; load_start begins a preload at word 0
// LOAD  | stream beats fill words in order; CPU held off
module dmem_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_loader_if.slave  bus
);
    localparam int ADDR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              accept;
    logic              last_beat;
    logic              start_load;
    logic              cpu_in_range;
    logic              cpu_wr;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [DATA_W-1:0] csum_q;
    logic [DATA_W-1:0] mem [DEPTH];

    assign cpu_in_range = ({1'b0, bus.cpu_addr} < DEPTH_EXT);
    assign start_load   = (state_q == IDLE) && bus.load_start;
    assign cpu_wr       = (state_q == IDLE) && bus.cpu_we && cpu_in_range;

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                accept    = bus.ld_valid;
                last_beat = bus.ld_valid && (bus.ld_last || (ptr_q == PTR_LAST));
                if (last_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LOAD);
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Load pointer plus count/checksum of the most recent load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
        end else if (start_load) begin
            ptr_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
        end else if (accept) begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            count_q <= count_q + (ADDR_W+1)'(1);
            csum_q  <= csum_q ^ bus.ld_data;
        end
    end

    // Storage array: stream beats in LOAD, CPU writes in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[ptr_q] <= bus.ld_data;
        end else if (cpu_wr) begin
            mem[bus.cpu_addr] <= bus.cpu_wdata;
        end
    end

    // Out-of-range CPU reads return zero
    always_comb begin
        bus.cpu_rdata = '0;
        if (cpu_in_range) begin
            bus.cpu_rdata = mem[bus.cpu_addr];
        end
    end

    assign bus.ld_ready = ready_q;
    assign bus.cpu_hold = ready_q;
    assign bus.ld_done  = done_q;
    assign bus.ld_count = count_q;
    assign bus.ld_csum  = csum_q;
endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader: an 8x8 instance for the load scenarios
// and a 5x16 instance for the non-power-of-two range and reset-abort cases.
module tb_dmem_loader;
    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    int   n_cmp;
    int   n_err;

    dmem_loader_if #(.DATA_W(8),  .DEPTH(8)) ifa ();
    dmem_loader_if #(.DATA_W(16), .DEPTH(5)) ifb ();

    dmem_loader #(.DATA_W(8),  .DEPTH(8)) u_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa));
    dmem_loader #(.DATA_W(16), .DEPTH(5)) u_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input string tag, input int addr, input logic [31:0] exp);
        ifa.cpu_addr = 3'(addr);
        #1;
        chk(tag, 32'(ifa.cpu_rdata), exp);
    endtask

    task automatic rd_b(input string tag, input int addr, input logic [31:0] exp);
        ifb.cpu_addr = 3'(addr);
        #1;
        chk(tag, 32'(ifb.cpu_rdata), exp);
    endtask

    logic [7:0] full_v [8];
    logic [7:0] after_short [8];

    initial begin
        n_cmp = 0;
        n_err = 0;
        full_v      = '{8'h22, 8'hA8, 8'h04, 8'h03, 8'h22, 8'h00, 8'h18, 8'h00};
        after_short = '{8'h09, 8'h03, 8'h04, 8'h03, 8'h22, 8'h00, 8'h18, 8'h00};

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        ifa.cpu_addr = '0; ifa.cpu_we = 1'b0; ifa.cpu_wdata = '0; ifa.load_start = 1'b0;
        ifa.ld_data = '0;  ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
        ifb.cpu_addr = '0; ifb.cpu_we = 1'b0; ifb.cpu_wdata = '0; ifb.load_start = 1'b0;
        ifb.ld_data = '0;  ifb.ld_valid = 1'b0; ifb.ld_last = 1'b0;
        #23;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        step();

        // ---- reset state
        for (int i = 0; i < 8; i++) rd_a("rst_rdata", i, 32'h0);
        chk("rst_ready", 32'(ifa.ld_ready), 32'd0);
        chk("rst_hold",  32'(ifa.cpu_hold), 32'd0);
        chk("rst_done",  32'(ifa.ld_done),  32'd0);
        chk("rst_count", 32'(ifa.ld_count), 32'd0);
        chk("rst_csum",  32'(ifa.ld_csum),  32'h0);

        // ---- full load, continuous valid
        ifa.load_start = 1'b1;
        step();
        ifa.load_start = 1'b0;
        chk("full_hold_start", 32'(ifa.cpu_hold), 32'd1);
        for (int i = 0; i < 8; i++) begin
            ifa.ld_valid = 1'b1;
            ifa.ld_data  = full_v[i];
            #1;
            chk("full_ready", 32'(ifa.ld_ready), 32'd1);
            chk("full_nodone", 32'(ifa.ld_done), 32'd0);
            step();
        end
        ifa.ld_valid = 1'b0;
        chk("full_ready_end", 32'(ifa.ld_ready), 32'd0);
        chk("full_hold_end",  32'(ifa.cpu_hold), 32'd0);
        chk("full_done",      32'(ifa.ld_done),  32'd1);
        chk("full_count",     32'(ifa.ld_count), 32'd8);
        chk("full_csum",      32'(ifa.ld_csum),  32'hB7);
        step();
        chk("full_done_drop", 32'(ifa.ld_done),  32'd0);
        chk("full_count_hold", 32'(ifa.ld_count), 32'd8);
        for (int i = 0; i < 8; i++) rd_a("full_rdata", i, 32'(full_v[i]));

        // ---- short load; ld_last without valid is ignored
        ifa.load_start = 1'b1;
        step();
        ifa.load_start = 1'b0;
        ifa.ld_valid = 1'b0;
        ifa.ld_last  = 1'b1;
        step();
        chk("short_last_novalid_ready", 32'(ifa.ld_ready), 32'd1);
        chk("short_last_novalid_count", 32'(ifa.ld_count), 32'd0);
        ifa.ld_valid = 1'b1; ifa.ld_last = 1'b0; ifa.ld_data = 8'h09;
        step();
        chk("short_mid_ready", 32'(ifa.ld_ready), 32'd1);
        ifa.ld_last = 1'b1; ifa.ld_data = 8'h03;
        step();
        ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
        chk("short_done",  32'(ifa.ld_done),  32'd1);
        chk("short_ready", 32'(ifa.ld_ready), 32'd0);
        chk("short_count", 32'(ifa.ld_count), 32'd2);
        chk("short_csum",  32'(ifa.ld_csum),  32'h0A);
        step();
        chk("short_done_drop", 32'(ifa.ld_done), 32'd0);
        for (int i = 0; i < 8; i++) rd_a("short_rdata", i, 32'(after_short[i]));

        // ---- gappy stream, ignored CPU write and ignored load_start mid-load
        ifa.load_start = 1'b1;
        step();
        ifa.load_start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            ifa.ld_valid   = (c % 2 == 0);
            ifa.ld_data    = (c % 2 == 0) ? 8'(8'h11 * (c / 2 + 1)) : 8'hEE;
            ifa.cpu_we     = (c == 9);
            ifa.cpu_addr   = 3'd3;
            ifa.cpu_wdata  = 8'hFF;
            ifa.load_start = (c == 11);
            #1;
            chk("gap_hold", 32'(ifa.cpu_hold), 32'd1);
            step();
        end
        ifa.ld_valid = 1'b0; ifa.cpu_we = 1'b0; ifa.load_start = 1'b0;
        chk("gap_done",  32'(ifa.ld_done),  32'd1);
        chk("gap_hold_end", 32'(ifa.cpu_hold), 32'd0);
        chk("gap_count", 32'(ifa.ld_count), 32'd8);
        chk("gap_csum",  32'(ifa.ld_csum),  32'h88);
        step();
        for (int i = 0; i < 8; i++) rd_a("gap_rdata", i, 32'(8'(8'h11 * (i + 1))));

        // ---- IDLE CPU write
        ifa.cpu_we = 1'b1; ifa.cpu_addr = 3'd6; ifa.cpu_wdata = 8'h5A;
        step();
        ifa.cpu_we = 1'b0;
        rd_a("idle_wr", 6, 32'h5A);
        ifa.cpu_we = 1'b1; ifa.cpu_addr = 3'd7; ifa.cpu_wdata = 8'h3C;
        step();
        ifa.cpu_we = 1'b0;
        rd_a("idle_wr_top", 7, 32'h3C);

        // ---- write coincident with load_start lands, then beat 6 overwrites it
        ifa.cpu_we = 1'b1; ifa.cpu_addr = 3'd6; ifa.cpu_wdata = 8'hC3; ifa.load_start = 1'b1;
        step();
        ifa.cpu_we = 1'b0; ifa.load_start = 1'b0;
        rd_a("start_wr_lands", 6, 32'hC3);
        chk("start_wr_count_clr", 32'(ifa.ld_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ifa.ld_valid = 1'b1;
            ifa.ld_data  = 8'(8'hB0 + i);
            step();
        end
        ifa.ld_valid = 1'b0;
        chk("b2b_done", 32'(ifa.ld_done), 32'd1);
        rd_a("start_wr_overwritten", 6, 32'hB6);
        // back-to-back: load_start during the ld_done cycle
        ifa.load_start = 1'b1;
        step();
        ifa.load_start = 1'b0;
        chk("b2b_ready", 32'(ifa.ld_ready), 32'd1);
        chk("b2b_done_drop", 32'(ifa.ld_done), 32'd0);
        chk("b2b_count_clr", 32'(ifa.ld_count), 32'd0);
        chk("b2b_csum_clr",  32'(ifa.ld_csum),  32'h0);
        ifa.ld_valid = 1'b1; ifa.ld_last = 1'b1; ifa.ld_data = 8'h7E;
        step();
        ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
        chk("b2b_second_done",  32'(ifa.ld_done),  32'd1);
        chk("b2b_second_count", 32'(ifa.ld_count), 32'd1);
        chk("b2b_second_csum",  32'(ifa.ld_csum),  32'h7E);
        rd_a("b2b_word0", 0, 32'h7E);
        rd_a("b2b_word1", 1, 32'hB1);

        // ---- DEPTH=5, DATA_W=16: out-of-range access
        ifb.cpu_we = 1'b1; ifb.cpu_addr = 3'd7; ifb.cpu_wdata = 16'hBEEF;
        step();
        ifb.cpu_we = 1'b0;
        rd_b("b_oor_read", 7, 32'h0);
        for (int i = 0; i < 5; i++) rd_b("b_oor_nowrite", i, 32'h0);
        ifb.cpu_we = 1'b1; ifb.cpu_addr = 3'd4; ifb.cpu_wdata = 16'h1234;
        step();
        ifb.cpu_we = 1'b0;
        rd_b("b_top_wr", 4, 32'h1234);

        // full 5-word load ends at the last word without ld_last
        ifb.load_start = 1'b1;
        step();
        ifb.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifb.ld_valid = 1'b1;
            ifb.ld_data  = 16'(16'h1111 * (i + 1));
            step();
        end
        ifb.ld_valid = 1'b0;
        chk("b_full_done",  32'(ifb.ld_done),  32'd1);
        chk("b_full_count", 32'(ifb.ld_count), 32'd5);
        chk("b_full_csum",  32'(ifb.ld_csum),  32'h1111);
        rd_b("b_full_w4", 4, 32'h5555);
        step();

        // reset 3 beats into a load
        ifb.load_start = 1'b1;
        step();
        ifb.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifb.ld_valid = 1'b1;
            ifb.ld_data  = 16'hA000 + 16'(i);
            step();
        end
        chk("b_pre_abort_count", 32'(ifb.ld_count), 32'd3);
        #2;
        rst_n_b = 1'b0;
        #1;
        chk("b_abort_ready", 32'(ifb.ld_ready), 32'd0);
        chk("b_abort_hold",  32'(ifb.cpu_hold), 32'd0);
        chk("b_abort_done",  32'(ifb.ld_done),  32'd0);
        chk("b_abort_count", 32'(ifb.ld_count), 32'd0);
        for (int i = 0; i < 5; i++) rd_b("b_abort_clear", i, 32'h0);
        ifb.ld_valid = 1'b0;
        step();
        rst_n_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("b_abort_no_done", 32'(ifb.ld_done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
